// File: rtl/host_cmd_rx.sv
// host_cmd_rx: parses checksummed host command frames (SYNC, CMD, payload, CHK)
// arriving from uart_rx. It loads the key, plaintext and delay registers and
// issues the run strobe that starts a trace-capture batch.
module host_cmd_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned KEY_BYTES      = 10,
    parameter int unsigned PT_BYTES       = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [79:0] KEY_DEFAULT    = 80'h3b6a8cf71e295d0b4f2e,
    parameter logic [7:0]  DELAY_DEFAULT  = 8'd5
) (
    input  logic        clk,
    input  logic        c10_resetn,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        busy,
    output logic [79:0] key,
    output logic [63:0] plaintext,
    output logic [7:0]  delay,
    output logic [7:0]  run_count,
    output logic        run_start,
    output logic        cmd_done,
    output logic        err_pulse,
    output logic [2:0]  err_code,
    output logic [15:0] frames_ok
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_SET_KEY   = 8'h01;
    localparam logic [7:0] CMD_SET_PT    = 8'h02;
    localparam logic [7:0] CMD_SET_DELAY = 8'h03;
    localparam logic [7:0] CMD_RUN       = 8'h04;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CHKSUM  = 3'd1;
    localparam logic [2:0] ERR_BADCMD  = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_BUSY    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_PAYLOAD,
        ST_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    xor_q, xor_d;
    logic [79:0]   shadow_q, shadow_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [79:0]   key_q, key_d;
    logic [63:0]   pt_q, pt_d;
    logic [7:0]    delay_q, delay_d;
    logic [7:0]    run_count_q, run_count_d;
    logic          run_start_q, run_start_d;
    logic          cmd_done_q, cmd_done_d;
    logic          err_pulse_q, err_pulse_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [15:0]   frames_ok_q, frames_ok_d;

    // Frame parser: next state, shadow/check accumulation, commit and error handling.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        shadow_d    = shadow_q;
        timer_d     = (state_q == ST_IDLE) ? '0 : timer_q + TW'(1);
        key_d       = key_q;
        pt_d        = pt_q;
        delay_d     = delay_q;
        run_count_d = run_count_q;
        run_start_d = 1'b0;
        cmd_done_d  = 1'b0;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        frames_ok_d = frames_ok_q;

        if (rx_dv) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    cmd_d = rx_byte;
                    xor_d = rx_byte;
                    case (rx_byte)
                        CMD_SET_KEY: begin
                            cnt_d   = 8'(KEY_BYTES);
                            state_d = ST_PAYLOAD;
                        end
                        CMD_SET_PT: begin
                            cnt_d   = 8'(PT_BYTES);
                            state_d = ST_PAYLOAD;
                        end
                        CMD_SET_DELAY, CMD_RUN: begin
                            cnt_d   = 8'd1;
                            state_d = ST_PAYLOAD;
                        end
                        default: begin
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_BADCMD;
                            state_d     = ST_IDLE;
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    shadow_d = {shadow_q[71:0], rx_byte};
                    xor_d    = xor_q ^ rx_byte;
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    state_d = ST_IDLE;
                    if (rx_byte != xor_q) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_CHKSUM;
                    end else if (busy) begin
                        err_pulse_d = 1'b1;
                        err_code_d  = ERR_BUSY;
                    end else begin
                        cmd_done_d  = 1'b1;
                        err_code_d  = ERR_NONE;
                        frames_ok_d = frames_ok_q + 16'd1;
                        case (cmd_q)
                            CMD_SET_KEY:   key_d   = shadow_q;
                            CMD_SET_PT:    pt_d    = shadow_q[63:0];
                            CMD_SET_DELAY: delay_d = shadow_q[7:0];
                            default: begin
                                run_count_d = shadow_q[7:0];
                                run_start_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && timer_q == TIMER_LAST) begin
            timer_d     = '0;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end
    end

    // State and output registers, restored to their defaults by the async reset.
    always_ff @(posedge clk or negedge c10_resetn) begin
        if (!c10_resetn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            xor_q       <= '0;
            shadow_q    <= '0;
            timer_q     <= '0;
            key_q       <= KEY_DEFAULT;
            pt_q        <= '0;
            delay_q     <= DELAY_DEFAULT;
            run_count_q <= '0;
            run_start_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            frames_ok_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            shadow_q    <= shadow_d;
            timer_q     <= timer_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            delay_q     <= delay_d;
            run_count_q <= run_count_d;
            run_start_q <= run_start_d;
            cmd_done_q  <= cmd_done_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            frames_ok_q <= frames_ok_d;
        end
    end

    assign key       = key_q;
    assign plaintext = pt_q;
    assign delay     = delay_q;
    assign run_count = run_count_q;
    assign run_start = run_start_q;
    assign cmd_done  = cmd_done_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign frames_ok = frames_ok_q;

endmodule

// File: tb/tb_host_cmd_rx.sv
// Testbench for host_cmd_rx: directed frames plus randomized frames checked
// against a frame-level reference model of the command protocol.
module tb_host_cmd_rx;

    localparam int unsigned TO = 40;
    localparam logic [79:0] KEY_DEF = 80'h3b6a8cf71e295d0b4f2e;

    logic        clk = 1'b0;
    logic        c10_resetn;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        busy;
    logic [79:0] key;
    logic [63:0] plaintext;
    logic [7:0]  delay;
    logic [7:0]  run_count;
    logic        run_start;
    logic        cmd_done;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [15:0] frames_ok;

    host_cmd_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .c10_resetn(c10_resetn), .rx_dv(rx_dv), .rx_byte(rx_byte),
        .busy(busy), .key(key), .plaintext(plaintext), .delay(delay),
        .run_count(run_count), .run_start(run_start), .cmd_done(cmd_done),
        .err_pulse(err_pulse), .err_code(err_code), .frames_ok(frames_ok)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatched = 0;

    // Pulse counters observed by a free-running monitor.
    int n_done = 0;
    int n_err = 0;
    int n_run = 0;

    // Reference model state.
    logic [79:0] m_key;
    logic [63:0] m_pt;
    logic [7:0]  m_delay;
    logic [7:0]  m_run;
    logic [2:0]  m_err;
    logic [15:0] m_frames;
    int e_done = 0;
    int e_err = 0;
    int e_run = 0;

    logic [7:0] pl [0:9];

    // Count every pulse the DUT emits, sampled away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (cmd_done === 1'b1) n_done++;
        if (err_pulse === 1'b1) n_err++;
        if (run_start === 1'b1) n_run++;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key = KEY_DEF; m_pt = '0; m_delay = 8'd5; m_run = '0; m_err = '0; m_frames = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".key"}, key, m_key);
        check({tag, ".pt"}, {16'h0, plaintext}, {16'h0, m_pt});
        check({tag, ".delay"}, {72'h0, delay}, {72'h0, m_delay});
        check({tag, ".run_count"}, {72'h0, run_count}, {72'h0, m_run});
        check({tag, ".err_code"}, {77'h0, err_code}, {77'h0, m_err});
        check({tag, ".frames_ok"}, {64'h0, frames_ok}, {64'h0, m_frames});
        check({tag, ".n_done"}, 80'(n_done), 80'(e_done));
        check({tag, ".n_err"}, 80'(n_err), 80'(e_err));
        check({tag, ".n_run"}, 80'(n_run), 80'(e_run));
    endtask

    // Present one byte for exactly one clock; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv = 1'b1;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send a frame; the model decides accept/reject from the protocol rules.
    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic corrupt,
                             input logic busy_at_chk, input logic rand_gaps);
        int len;
        logic [7:0] x;
        logic [7:0] chk;
        logic [79:0] sh;
        logic acc, rej, runp;
        len = (cmd == 8'h01) ? 10 : (cmd == 8'h02) ? 8 : (cmd == 8'h03 || cmd == 8'h04) ? 1 : 0;
        send_byte(8'hA5);
        if (rand_gaps) gap($urandom_range(0, 3));
        send_byte(cmd);
        acc = 1'b0; rej = 1'b0; runp = 1'b0;
        if (len == 0) begin
            rej = 1'b1;
            m_err = 3'd2;
        end else begin
            x = cmd;
            sh = '0;
            for (int i = 0; i < len; i++) begin
                if (rand_gaps) begin
                    busy = 1'($urandom_range(0, 1));
                    gap($urandom_range(0, 3));
                end
                send_byte(pl[i]);
                x = x ^ pl[i];
                sh = {sh[71:0], pl[i]};
            end
            chk = corrupt ? (x ^ (8'h01 << $urandom_range(0, 7))) : x;
            busy = busy_at_chk;
            if (rand_gaps) gap($urandom_range(0, 3));
            send_byte(chk);
            busy = 1'b0;
            if (corrupt) begin
                rej = 1'b1; m_err = 3'd1;
            end else if (busy_at_chk) begin
                rej = 1'b1; m_err = 3'd4;
            end else begin
                acc = 1'b1; m_err = 3'd0; m_frames = m_frames + 16'd1;
                case (cmd)
                    8'h01: m_key = sh;
                    8'h02: m_pt = sh[63:0];
                    8'h03: m_delay = sh[7:0];
                    default: begin m_run = sh[7:0]; runp = 1'b1; end
                endcase
            end
        end
        if (acc) e_done++;
        if (rej) e_err++;
        if (runp) e_run++;
        check({tag, ".cmd_done"}, 80'(cmd_done), 80'(acc));
        check({tag, ".err_pulse"}, 80'(err_pulse), 80'(rej));
        check({tag, ".run_start"}, 80'(run_start), 80'(runp));
        gap(1);
        check({tag, ".pulses_low"}, 80'({cmd_done, err_pulse, run_start}), 80'(0));
        check_outputs(tag);
    endtask

    initial begin
        int cyc;
        logic [7:0] cmd;
        int r;
        c10_resetn = 1'b0;
        rx_dv = 1'b0;
        rx_byte = 8'h00;
        busy = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        c10_resetn = 1'b1;
        gap(1);
        check_outputs("reset");

        // SET_DELAY 07
        pl[0] = 8'h07;
        run_frame("set_delay", 8'h03, 1'b0, 1'b0, 1'b0);

        // SET_PT good, then bad checksum
        pl[0] = 8'h00; pl[1] = 8'h11; pl[2] = 8'h22; pl[3] = 8'h33;
        pl[4] = 8'h44; pl[5] = 8'h55; pl[6] = 8'h66; pl[7] = 8'h77;
        run_frame("set_pt", 8'h02, 1'b0, 1'b0, 1'b0);
        check("set_pt.value", {16'h0, plaintext}, 80'h0011223344556677);
        run_frame("set_pt_badchk", 8'h02, 1'b1, 1'b0, 1'b0);

        // RUN accepted, then refused while busy
        pl[0] = 8'h10;
        run_frame("run", 8'h04, 1'b0, 1'b0, 1'b0);
        pl[0] = 8'h22;
        run_frame("run_busy", 8'h04, 1'b0, 1'b1, 1'b0);
        check("run_busy.count", {72'h0, run_count}, 80'h10);

        // Stray bytes, bad command, then bytes that must be ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        gap(2);
        check_outputs("stray");
        run_frame("bad_cmd", 8'h09, 1'b0, 1'b0, 1'b0);
        send_byte(8'h03);
        send_byte(8'h07);
        send_byte(8'h04);
        gap(2);
        check_outputs("ignored");

        // Timeout during SET_KEY after 5 payload bytes
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        cyc = 0;
        while (cyc < 3 * TO && err_pulse !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("timeout.latency", 80'(cyc), 80'(TO));
        m_err = 3'd3;
        e_err++;
        gap(1);
        check_outputs("timeout");
        for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
        run_frame("key_after_to", 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a SET_PT frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        c10_resetn = 1'b0;
        gap(2);
        model_reset();
        check("reset_mid.pulses", 80'({cmd_done, err_pulse, run_start}), 80'(0));
        c10_resetn = 1'b1;
        gap(1);
        check_outputs("reset_mid");
        pl[0] = 8'h3C;
        run_frame("after_reset", 8'h03, 1'b0, 1'b0, 1'b0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: cmd = 8'h01;
                2, 3: cmd = 8'h02;
                4, 5: cmd = 8'h03;
                6, 7: cmd = 8'h04;
                8: cmd = 8'($urandom_range(5, 255));
                default: cmd = 8'h00;
            endcase
            for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
            run_frame("random", cmd, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
